apb_bridge_ctrl: RTL and testbench
==================================

Name: apb_bridge_ctrl

Overview:
Parametrised, registered APB master bridge and slave mux. It succeeds the combinational APB fan-out in the peripheral subsystem. It accepts single transfers from the core-side bus through a valid/ready request and a one-cycle response. It runs the full APB4 IDLE/SETUP/ACCESS protocol to one of NUM_SLV peripherals (timer, PWM, UART, GPIO, SPI, I2C, ...). It adds decode-error and PREADY-timeout error generation.

Parameters:
NUM_SLV, 6, number of APB slaves (1..7 with SEL_W=3)
ADDR_W, 20, request/PADDR address width
DATA_W, 32, data width (multiple of 8)
SEL_LSB, 13, lowest address bit of the slave-select field
SEL_W, 3, width of the slave-select field
TIMEOUT, 255, max ACCESS cycles without PREADY before forced error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  transfer request
req_ready  out  1  bridge can accept a request
req_addr  in  ADDR_W  byte address
req_write  in  1  1 = write, 0 = read
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  slave PSLVERR, decode error or timeout
psel  out  NUM_SLV  one-hot PSEL
penable  out  1  shared PENABLE
pwrite  out  1  shared PWRITE
paddr  out  ADDR_W  shared PADDR, req_addr[SEL_LSB-1:0] zero-extended
pwdata  out  DATA_W  shared PWDATA
pstrb  out  DATA_W/8  shared PSTRB (all 0 on reads)
prdata  in  NUM_SLV*DATA_W  slave k read data at [k*DATA_W +: DATA_W]
pready  in  NUM_SLV  per-slave PREADY
pslverr  in  NUM_SLV  per-slave PSLVERR

Behaviour:
- Reset (rst=0, immediate, asynchronous): state=IDLE. psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. req_ready=1 once rst=1. Reset mid-transfer aborts the transfer and emits no response.
- Decode: field f = req_addr[SEL_LSB +: SEL_W].
  - f in 1..NUM_SLV selects slave f-1.
  - f=0 or f>NUM_SLV is a decode error.
  - With the defaults, 0x2000 maps to slave 0 and 0xC000 to slave 5.
- req_ready=1 only in IDLE. Accept on req_valid & req_ready. On accept, capture address, write flag, wdata, strb and the decoded index into registers.
- FSM:
  - IDLE: on accept, go to SETUP if decode is valid, else DERR.
  - SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the captured registers. Go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1, all other outputs held stable.
    - If pready[idx]=1: capture prdata slice (reads only, else 0) and pslverr[idx]. Go to RESP.
    - If pready[idx]=0 and TIMEOUT!=0 and counter==TIMEOUT-1: rdata=0, err=1. Go to RESP. Psel/penable drop on the next cycle.
    - Otherwise increment counter and stay.
  - DERR (1 cycle): no psel. rdata=0, err=1. Go to RESP.
  - RESP (1 cycle): rsp_valid=1 with registered rsp_rdata/rsp_err, psel=0, penable=0. Go to IDLE. The counter is cleared on entry to SETUP.
- Latency with a zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3. Each wait state adds 1 cycle. Throughput is one transfer per 4 cycles minimum. A decode error responds at cycle 2.
- pready/pslverr/prdata of unselected slaves are ignored.
- rsp_rdata/rsp_err hold their value after RESP until the next RESP.
- Counter width is $clog2(TIMEOUT+1). It must not wrap.
- pstrb = captured strb on writes, 0 on reads.
- psel is never multi-hot. penable=1 only in ACCESS.

Decomposition:
- Package apb_bridge_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, DERR, RESP}
  - localparam defaults for the slave-select field
  - address-map constants: TIMER/PWM/UART/GPIO/SPI/I2C field values 1..6
- One sub-module apb_addr_decode (combinational): addr → {valid, idx}, parametrised by NUM_SLV/SEL_LSB/SEL_W. FSM and datapath stay in the top.

Test Plan:
- Write 0xDEADBEEF to req_addr 0x02010 (slave 0), strb 0xF, slave pready tied 1 → psel=6'b000001 at cycles 1-2, penable only at cycle 2, paddr=0x00010, pwdata=0xDEADBEEF; rsp_valid at cycle 3, rsp_err=0.
- Read 0x0C004 (slave 5), slave 5 holds pready=0 for 3 ACCESS cycles, prdata=0x12345678 → rsp_valid 6 cycles after accept, rsp_rdata=0x12345678, pstrb=0, req_ready=0 throughout.
- Read 0x0E000 (f=7) and read 0x00100 (f=0) → no psel ever asserted, rsp_valid at cycle 2, rsp_err=1, rsp_rdata=0.
- TIMEOUT=4, slave 2 never raises pready → penable high for exactly 4 cycles, then rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Slave 3 returns pready=1, pslverr=1 on a write → rsp_err=1. pready/pslverr toggled on unselected slaves during the transfer → no effect on the response.
- Assert rst low while in ACCESS → psel/penable/rsp_valid go to 0 in the same cycle, no rsp_valid after release, and the next request completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state type, select-field defaults and peripheral address map
package apb_bridge_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DERR, RESP} apb_state_e;
    localparam int SEL_LSB_DEF = 13;
    localparam int SEL_W_DEF   = 3;
    localparam logic [2:0] SEL_TIMER = 3'd1;
    localparam logic [2:0] SEL_PWM   = 3'd2;
    localparam logic [2:0] SEL_UART  = 3'd3;
    localparam logic [2:0] SEL_GPIO  = 3'd4;
    localparam logic [2:0] SEL_SPI   = 3'd5;
    localparam logic [2:0] SEL_I2C   = 3'd6;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the slave-select field to a slave index; field 0 and values above NUM_SLV are errors
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int NUM_SLV = 6,
    parameter int SEL_LSB = SEL_LSB_DEF,
    parameter int SEL_W   = SEL_W_DEF
)(
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [SEL_W-1:0]  o_idx
);
    logic [SEL_W-1:0] w_f;
    logic             w_unused;
    assign w_f      = i_addr[SEL_LSB +: SEL_W];
    assign o_valid  = (w_f != '0) && (w_f <= SEL_W'(NUM_SLV));
    assign o_idx    = w_f - SEL_W'(1);
    assign w_unused = ^{i_addr[ADDR_W-1:SEL_LSB+SEL_W], i_addr[SEL_LSB-1:0]};
endmodule

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: registered APB4 master bridge and slave mux with decode-error and PREADY-timeout responses
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLV = 6,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = SEL_LSB_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int TIMEOUT = 255
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e         r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_valid;
    logic [SEL_W-1:0]   w_idx;
    logic               w_rdy;
    logic               w_tmo;
    logic [DATA_W-1:0]  w_prd;

    apb_addr_decode #(
        .ADDR_W (ADDR_W),
        .NUM_SLV(NUM_SLV),
        .SEL_LSB(SEL_LSB),
        .SEL_W  (SEL_W)
    ) u_dec (
        .i_addr (req_addr),
        .o_valid(w_valid),
        .o_idx  (w_idx)
    );

    assign req_ready = (r_state == IDLE);
    assign w_rdy     = pready[r_idx];
    assign w_prd     = prdata[int'(r_idx) * DATA_W +: DATA_W];
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    if (w_valid) begin
                        r_state <= SETUP;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        psel    <= NUM_SLV'(1) << w_idx;
                        pwrite  <= req_write;
                        paddr   <= ADDR_W'(req_addr[SEL_LSB-1:0]);
                        pwdata  <= req_wdata;
                        pstrb   <= req_write ? req_strb : '0;
                    end else begin
                        r_state <= DERR;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: if (w_rdy || w_tmo) begin
                    // a ready slave wins over a timeout expiring in the same cycle
                    psel      <= '0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= (w_rdy && !pwrite) ? w_prd : '0;
                    rsp_err   <= w_rdy ? pslverr[r_idx] : 1'b1;
                    r_state   <= RESP;
                end else if (r_cnt != CNT_W'(TIMEOUT)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DERR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb_apb_bridge_ctrl: directed stimulus with a response scoreboard and an APB protocol monitor
module tb_apb_bridge_ctrl;
    localparam int NS = 6, AW = 20, DW = 32, SW = DW / 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        longint        t_acc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0] pready = '1, pslverr = '0;
    logic req_ready, rsp_valid, rsp_err, penable, pwrite;
    logic [DW-1:0] rsp_rdata, pwdata;
    logic [NS-1:0] psel;
    logic [AW-1:0] paddr;
    logic [SW-1:0] pstrb;

    exp_t exp_q[$];
    int checks = 0, errors = 0;

    apb_bridge_ctrl #(
        .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(13), .SEL_W(3), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // response scoreboard and protocol invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("psel_onehot0", 64'($onehot0(psel)), 64'd1);
            chk("penable_without_psel", 64'(penable && psel == '0), 64'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(($time - e.t_acc - 5) / 10 + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input logic [SW-1:0] s, input logic [DW-1:0] erd, input logic eerr,
                         input int elat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 64'(req_ready), 64'd1);
            return;
        end
        req_addr = a; req_write = w; req_wdata = wd; req_strb = s; req_valid = 1'b1;
        @(posedge clk);
        e.rdata = erd; e.err = eerr; e.lat = elat; e.t_acc = $time;
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] derr_a [2];
        int pen, n, seen;
        derr_a = '{20'h0E000, 20'h00100};
        for (int k = 0; k < NS; k++) prdata[k*DW +: DW] = 32'hBAD0_0000 | k;

        // reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_req_ready", 64'(req_ready), 64'd1);

        // zero-wait write to slave 0
        issue(20'h02010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
        @(negedge clk);
        chk("t1_psel_c1", 64'(psel), 64'h01);
        chk("t1_penable_c1", 64'(penable), 64'd0);
        chk("t1_paddr", 64'(paddr), 64'h00010);
        chk("t1_pwdata", 64'(pwdata), 64'hDEADBEEF);
        chk("t1_pstrb", 64'(pstrb), 64'hF);
        chk("t1_pwrite", 64'(pwrite), 64'd1);
        @(negedge clk);
        chk("t1_psel_c2", 64'(psel), 64'h01);
        chk("t1_penable_c2", 64'(penable), 64'd1);
        drain();

        // read slave 5 with three wait states
        pready = 6'b011111;
        prdata[5*DW +: DW] = 32'h12345678;
        issue(20'h0C004, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h12345678, 1'b0, 6);
        @(negedge clk);
        chk("t2_psel", 64'(psel), 64'h20);
        chk("t2_penable_c1", 64'(penable), 64'd0);
        chk("t2_pstrb", 64'(pstrb), 64'd0);
        chk("t2_pwrite", 64'(pwrite), 64'd0);
        chk("t2_paddr", 64'(paddr), 64'h00004);
        chk("t2_req_ready_c1", 64'(req_ready), 64'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("t2_penable_wait", 64'(penable), 64'd1);
            chk("t2_req_ready_wait", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 pready[5] = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("t2_rdata_hold", 64'(rsp_rdata), 64'h12345678);

        // decode errors: field 7 and field 0
        pready = '1;
        for (int i = 0; i < 2; i++) begin
            issue(derr_a[i], 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 2);
            @(negedge clk);
            chk("t3_psel_c1", 64'(psel), 64'd0);
            @(negedge clk);
            chk("t3_psel_c2", 64'(psel), 64'd0);
            drain();
        end

        // timeout on slave 2, then a normal transfer to it
        pready = 6'b111011;
        issue(20'h06000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 6);
        pen = 0; n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            pen += int'(penable);
            n++;
            @(negedge clk);
        end
        chk("t4_penable_cycles", 64'(pen), 64'd4);
        drain();
        pready[2] = 1'b1;
        prdata[2*DW +: DW] = 32'hA5A50002;
        issue(20'h06008, 1'b0, 32'h0, 4'h0, 32'hA5A50002, 1'b0, 3);
        drain();

        // slave error on write to slave 3
        pslverr = 6'b001000;
        issue(20'h08000, 1'b1, 32'hCAFEF00D, 4'h3, 32'h0, 1'b1, 3);
        @(negedge clk);
        chk("t5_pstrb", 64'(pstrb), 64'h3);
        drain();

        // unselected slaves toggling while slave 1 inserts one wait state
        prdata[1*DW +: DW] = 32'h11110001;
        pready = 6'b111101;
        pslverr = 6'b111101;
        issue(20'h04000, 1'b0, 32'h0, 4'h0, 32'h11110001, 1'b0, 4);
        pready ^= 6'b111101; pslverr ^= 6'b111101;
        @(posedge clk);
        #1 pready ^= 6'b111101; pslverr ^= 6'b111101;
        @(posedge clk);
        #1 pready ^= 6'b111101; pslverr ^= 6'b111101; pready[1] = 1'b1;
        drain();

        // reset asserted during ACCESS
        pslverr = '0;
        pready = 6'b101111;
        issue(20'h0A000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 3);
        @(posedge clk);
        @(posedge clk);
        #2 chk("t6_penable_before", 64'(penable), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_psel_rst", 64'(psel), 64'd0);
        chk("t6_penable_rst", 64'(penable), 64'd0);
        chk("t6_rsp_valid_rst", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        chk("t6_no_rsp_after_rst", 64'(seen), 64'd0);
        pready = '1;
        prdata[4*DW +: DW] = 32'h44440004;
        issue(20'h0A00C, 1'b0, 32'h0, 4'h0, 32'h44440004, 1'b0, 3);
        drain();

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
